// File: rtl/pio_in_capture_avmm_if.sv
// Avalon-MM slave bus bundle for the PIO input capture block.
// The bus master (host bridge / testbench) drives the request side.
interface pio_in_capture_avmm_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input  address, read, write, writedata, output readdata);
  modport master (output address, read, write, writedata, input  readdata);
endinterface

// File: rtl/pio_in_capture_avmm.sv
// PIO input capture: per-pin synchroniser, edge detect into sticky W1C bits, level IRQ.
// Optional per-pin debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pio_in_capture_lane #(
  parameter int SYNC_DEPTH      = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_val;
  logic                  prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_DEPTH-2:0], pin_i};
  end
  assign sync_val = sync_q[SYNC_DEPTH-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Count consecutive cycles the synchronised level disagrees with the filtered one.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_val != filt_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == DB_MAX) begin
        filt_d = sync_val;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
  assign filt_o = filt_q;
`else
  localparam int unused_db = DEBOUNCE_CYCLES;
  assign filt_o = sync_val;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) prev_q <= 1'b0;
    else         prev_q <= filt_o;
  end

  assign rise_o = filt_o & ~prev_q;
  assign fall_o = ~filt_o & prev_q;
endmodule

module pio_in_capture_avmm #(
  parameter int PIO_WIDTH       = 8,
  parameter int SYNC_DEPTH      = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [PIO_WIDTH-1:0]  pio_i,
  pio_in_capture_avmm_if.slave  avs,
  output logic                  irq_o
);
  localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd1, A_CAP = 2'd2, A_CFG = 2'd3;

  logic [PIO_WIDTH-1:0] filt_val, rise, fall, evt;
  logic [PIO_WIDTH-1:0] mask_q, cap_q, cap_d, rise_en_q, fall_en_q, w1c;
  logic [31:0]          rd_mux, rdata_q;
  logic                 irq_q;
  logic                 wr_mask, wr_cap, wr_cfg;
  logic                 unused_wdata;

  for (genvar g = 0; g < PIO_WIDTH; g++) begin : g_lane
    pio_in_capture_lane #(
      .SYNC_DEPTH      (SYNC_DEPTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lane (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .pin_i  (pio_i[g]),
      .filt_o (filt_val[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  assign evt     = (rise & rise_en_q) | (fall & fall_en_q);
  assign wr_mask = avs.write && (avs.address == A_MASK);
  assign wr_cap  = avs.write && (avs.address == A_CAP);
  assign wr_cfg  = avs.write && (avs.address == A_CFG);
  assign w1c     = wr_cap ? avs.writedata[PIO_WIDTH-1:0] : '0;
  // A fresh event beats a same-cycle clear so no edge is ever lost.
  assign cap_d   = evt | (cap_q & ~w1c);
  assign unused_wdata = &{1'b0, avs.writedata};

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      A_DATA: rd_mux[PIO_WIDTH-1:0] = filt_val;
      A_MASK: rd_mux[PIO_WIDTH-1:0] = mask_q;
      A_CAP:  rd_mux[PIO_WIDTH-1:0] = cap_q;
      default: begin
        rd_mux[PIO_WIDTH-1:0]   = rise_en_q;
        rd_mux[16+:PIO_WIDTH]   = fall_en_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      cap_q <= cap_d;
      irq_q <= |(cap_q & mask_q);
      if (wr_mask) mask_q <= avs.writedata[PIO_WIDTH-1:0];
      if (wr_cfg) begin
        rise_en_q <= avs.writedata[PIO_WIDTH-1:0];
        fall_en_q <= avs.writedata[16+:PIO_WIDTH];
      end
      if (avs.read) rdata_q <= rd_mux;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq_o        = irq_q;
endmodule
